// File: rtl/seg_seq_scan_pkg.sv
// Shared definitions for the seven-segment sequencer: segment font (active-high),
// FSM state encoding and pushbutton indices.
package seg_seq_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int BTN_RUN  = 0;
    localparam int BTN_CLR  = 1;
    localparam int BTN_DIR  = 2;
    localparam int BTN_STEP = 3;

    // Segment order {dp,g,f,e,d,c,b,a}, 1 = lit
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [7:0] seg_font(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_seq_scan_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, symmetric DEB_CYC-sample debounce,
// and a single-cycle pulse on each recognised press (button is active-low).
module seg_seq_scan_btn_debounce
    import seg_seq_scan_pkg::*;
#(
    parameter int DEB_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic          sync_p0;
    logic          sync_p1;
    logic          held;
    logic [CW-1:0] cnt;

    // held=1 means pressed; a sample equal to held disagrees with the stable level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            held    <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= btn_n;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            if (sync_p1 == held) begin
                if (cnt == CW'(DEB_CYC - 1)) begin
                    cnt   <= '0;
                    held  <= ~held;
                    press <= ~held;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/seg_seq_scan.sv
// N-digit BCD up/down counter with run/pause/step control on a multiplexed 7-seg display.
// Optional macro LZ_BLANK_EN blanks leading zeros (digit 0 always shown).
module seg_seq_scan
    import seg_seq_scan_pkg::*;
#(
    parameter int NUM_DIG     = 4,
    parameter int CLK_HZ      = 27_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int TICK_HZ     = 10,
    parameter int DEB_MS      = 20,
    parameter int DIG_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           button,
    output logic [NUM_DIG-1:0]   dig,
    output logic [7:0]           smg,
    output logic [4*NUM_DIG-1:0] count_o,
    output logic                 run_o
);

    localparam int CNT_W    = 4 * NUM_DIG;
    localparam int SCAN_DIV = (CLK_HZ / SCAN_HZ > 0) ? CLK_HZ / SCAN_HZ : 1;
    localparam int TICK_DIV = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
    localparam int DEB_CYC  = (CLK_HZ / 1000 * DEB_MS > 0) ? CLK_HZ / 1000 * DEB_MS : 1;
    localparam int IW       = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [NUM_DIG-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? '1 : '0;
    localparam logic [7:0]         SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

    function automatic logic [CNT_W-1:0] bcd_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        logic             c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] bcd_dec(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        logic             b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [3:0]       press;
    state_t           state;
    logic             dir;
    logic [CNT_W-1:0] count;
    logic [TW-1:0]    tick;
    logic [SW-1:0]    scan_cnt;
    logic [IW-1:0]    idx;
    logic             tick_hit;
    logic             step_en;

    for (genvar b = 0; b < 4; b++) begin : g_btn
        seg_seq_scan_btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_n (button[b]),
            .press (press[b])
        );
    end

    assign tick_hit = (state == ST_RUN) && (tick == TW'(TICK_DIV - 1));
    assign step_en  = tick_hit || (press[BTN_STEP] && (state != ST_RUN));

    // Control FSM and BCD counter; clear overrides every other request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            run_o <= 1'b0;
            dir   <= 1'b0;
            count <= '0;
        end else if (press[BTN_CLR]) begin
            state <= ST_IDLE;
            run_o <= 1'b0;
            count <= '0;
        end else begin
            if (press[BTN_DIR])
                dir <= ~dir;
            if (step_en)
                count <= dir ? bcd_dec(count) : bcd_inc(count);
            if (press[BTN_RUN]) begin
                case (state)
                    ST_RUN: begin
                        state <= ST_PAUSE;
                        run_o <= 1'b0;
                    end
                    default: begin
                        state <= ST_RUN;
                        run_o <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick <= '0;
        else if (state != ST_RUN || tick == TW'(TICK_DIV - 1))
            tick <= '0;
        else
            tick <= tick + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(NUM_DIG - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    logic [3:0]         digit_p0;
    logic [IW-1:0]      hi_nz_p0;
    logic [7:0]         seg_p0;
    logic [NUM_DIG-1:0] onehot_p0;

    always_comb begin
        digit_p0 = 4'd0;
        hi_nz_p0 = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (IW'(i) == idx)
                digit_p0 = count[4*i +: 4];
            if (count[4*i +: 4] != 4'd0)
                hi_nz_p0 = IW'(i);
        end
        seg_p0 = seg_font(digit_p0);
`ifdef LZ_BLANK_EN
        if (idx > hi_nz_p0)
            seg_p0 = SEG_BLANK;
`endif
        if (idx == '0 && dir)
            seg_p0[7] = 1'b1;
        onehot_p0 = NUM_DIG'(1) << idx;
    end

    // Display register stage: one cycle behind scan index / count
    logic [NUM_DIG-1:0] dig_p1;
    logic [7:0]         smg_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_p1 <= DIG_OFF;
            smg_p1 <= SEG_OFF;
        end else begin
            dig_p1 <= onehot_p0 ^ DIG_OFF;
            smg_p1 <= seg_p0 ^ SEG_OFF;
        end
    end

    assign dig     = dig_p1;
    assign smg     = smg_p1;
    assign count_o = count;

endmodule

// File: tb/tb_seg_seq_scan.sv
// Directed bench for seg_seq_scan with a fast clock scale (SCAN_DIV=4, TICK_DIV=10, DEB_CYC=2).
module tb_seg_seq_scan;

    logic        clk;
    logic        rst_n;
    logic [3:0]  button;
    logic [3:0]  dig;
    logic [7:0]  smg;
    logic [15:0] count_o;
    logic        run_o;

    int n_chk  = 0;
    int n_fail = 0;

    seg_seq_scan #(
        .NUM_DIG     (4),
        .CLK_HZ      (1000),
        .SCAN_HZ     (250),
        .TICK_HZ     (100),
        .DEB_MS      (2),
        .DIG_ACT_LOW (1),
        .SEG_ACT_LOW (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .button  (button),
        .dig     (dig),
        .smg     (smg),
        .count_o (count_o),
        .run_o   (run_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold the given buttons low long enough to register, then release and let them settle
    task automatic press(input logic [3:0] mask);
        button = button & ~mask;
        wait_cyc(6);
        button = button | mask;
        wait_cyc(6);
    endtask

    task automatic check_digit(input string tag, input int idx, input logic [7:0] exp);
        logic [3:0] want;
        logic       seen;
        want = ~(4'b0001 << idx);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (dig === want) seen = 1'b1;
            else wait_cyc(1);
        end
        check({tag, "_seen"}, {31'd0, seen}, 32'd1);
        check(tag, {24'd0, smg}, {24'd0, exp});
    endtask

    initial begin
        rst_n  = 1'b0;
        button = 4'hF;
        wait_cyc(3);

        // Reset state and digit walk
        check("rst_dig", {28'd0, dig}, 32'h0000000F);
        check("rst_smg", {24'd0, smg}, 32'h000000FF);
        check("rst_cnt", {16'd0, count_o}, 32'h0);
        check("rst_run", {31'd0, run_o}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(1);
        check("walk0", {28'd0, dig}, 32'hE);
        check("walk0_smg", {24'd0, smg}, 32'hC0);
        wait_cyc(4);
        check("walk1", {28'd0, dig}, 32'hD);
        wait_cyc(4);
        check("walk2", {28'd0, dig}, 32'hB);
        wait_cyc(4);
        check("walk3", {28'd0, dig}, 32'h7);
        wait_cyc(4);
        check("walk_wrap", {28'd0, dig}, 32'hE);

        // Run: first step TICK_DIV cycles after entering RUN
        button[0] = 1'b0;
        wait_cyc(5);
        check("run_on", {31'd0, run_o}, 32'h1);
        wait_cyc(1);
        button[0] = 1'b1;
        wait_cyc(8);
        check("run_pre_tick", {16'd0, count_o}, 32'h0000);
        wait_cyc(1);
        check("run_tick1", {16'd0, count_o}, 32'h0001);
        wait_cyc(40);
        check("run_tick5", {16'd0, count_o}, 32'h0005);
        button[0] = 1'b0;
        wait_cyc(5);
        check("pause_run", {31'd0, run_o}, 32'h0);
        check("pause_cnt", {16'd0, count_o}, 32'h0005);
        wait_cyc(1);
        button[0] = 1'b1;
        wait_cyc(20);
        check("pause_frozen", {16'd0, count_o}, 32'h0005);

        // Down direction, steps in PAUSE, borrow wrap 0 -> 9999 and dp on digit 0
        press(4'b0100);
        check("dir_nochg", {16'd0, count_o}, 32'h0005);
        for (int i = 0; i < 5; i++) press(4'b1000);
        check("down_zero", {16'd0, count_o}, 32'h0000);
        press(4'b1000);
        check("down_wrap", {16'd0, count_o}, 32'h9999);
        check("down_paused", {31'd0, run_o}, 32'h0);
        check_digit("dp_d0", 0, 8'h10);
        check_digit("nodp_d3", 3, 8'h90);

        // Clear, up direction, preload 0999 then carry across three digits
        press(4'b0010);
        check("clr_cnt", {16'd0, count_o}, 32'h0000);
        press(4'b0100);
        for (int i = 0; i < 999; i++) press(4'b1000);
        check("preload", {16'd0, count_o}, 32'h0999);
        press(4'b1000);
        check("carry", {16'd0, count_o}, 32'h1000);
        button[3] = 1'b0;
        wait_cyc(1);
        button[3] = 1'b1;
        wait_cyc(12);
        check("glitch", {16'd0, count_o}, 32'h1000);

        // btn0+btn3 together in PAUSE: step then RUN
        press(4'b0010);
        press(4'b0001);
        press(4'b0001);
        check("pause2_cnt", {16'd0, count_o}, 32'h0001);
        check("pause2_run", {31'd0, run_o}, 32'h0);
        press(4'b1001);
        check("stepgo_cnt", {16'd0, count_o}, 32'h0002);
        check("stepgo_run", {31'd0, run_o}, 32'h1);
        press(4'b1000);
        check("run_step_ign", {16'd0, count_o}, 32'h0003);

        // Clear and start together in RUN: clear wins
        press(4'b0011);
        check("clrwin_cnt", {16'd0, count_o}, 32'h0000);
        check("clrwin_run", {31'd0, run_o}, 32'h0);

        // Count 0042 display, optional leading-zero blanking
        for (int i = 0; i < 42; i++) press(4'b1000);
        check("cnt42", {16'd0, count_o}, 32'h0042);
`ifdef LZ_BLANK_EN
        check_digit("d3", 3, 8'hFF);
        check_digit("d2", 2, 8'hFF);
`else
        check_digit("d3", 3, 8'hC0);
        check_digit("d2", 2, 8'hC0);
`endif
        check_digit("d1", 1, 8'h99);
        check_digit("d0", 0, 8'hA4);

        // Asynchronous reset mid-scan
        wait_cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dig", {28'd0, dig}, 32'hF);
        check("arst_smg", {24'd0, smg}, 32'hFF);
        check("arst_cnt", {16'd0, count_o}, 32'h0);
        check("arst_run", {31'd0, run_o}, 32'h0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(1);
        check("post_rst_dig", {28'd0, dig}, 32'hE);
        check("post_rst_smg", {24'd0, smg}, 32'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
